// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite types and constants for the round-robin master.
// Pipeline slot records are sized for up to 32-bit address/data and 8 requesters.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HWORD = 3'b001,
    HSIZE_WORD  = 3'b010
  } hsize_t;

  typedef enum logic {
    ERR_RUN  = 1'b0,
    ERR_HOLD = 1'b1
  } err_state_t;

  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  localparam int SLOT_ADDR_W = 32;
  localparam int SLOT_DATA_W = 32;
  localparam int SLOT_ID_W   = 3;

  // Address-phase slot: everything needed to (re)issue a transfer.
  typedef struct packed {
    logic                   valid;
    logic [SLOT_ADDR_W-1:0] addr;
    logic                   write;
    logic [2:0]             size;
    logic [SLOT_ID_W-1:0]   id;
    logic [SLOT_DATA_W-1:0] wdata;
  } slot_t;

  // Data-phase slot: only what the data phase and the response need.
  typedef struct packed {
    logic                   valid;
    logic                   write;
    logic [SLOT_ID_W-1:0]   id;
    logic [SLOT_DATA_W-1:0] wdata;
  } dslot_t;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb3lite_rr_master_if.sv
// Requester-side and AHB-side signal bundle for the round-robin master.
// The master modport is the DUT view; the slave modport is the environment view.
interface ahb3lite_rr_master_if
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int NUM_REQ    = 2
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][HADDR_SIZE-1:0] req_addr;
  logic [NUM_REQ-1:0]                 req_write;
  logic [NUM_REQ-1:0][2:0]            req_size;
  logic [NUM_REQ-1:0][HDATA_SIZE-1:0] req_wdata;

  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [HDATA_SIZE-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  htrans_t               HTRANS;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    input  req_valid, req_addr, req_write, req_size, req_wdata,
    output req_ready,
    output rsp_valid, rsp_id, rsp_rdata, rsp_err,
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output req_valid, req_addr, req_write, req_size, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: search starts at r_ptr, which moves one past each winner.
// After reset requester 0 has top priority.
module rr_arbiter
  import ahb3lite_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_idx,
  output logic               o_gnt_valid
);

  logic [ID_W-1:0]               r_ptr;
  logic [NUM_REQ-1:0][ID_W-1:0]  w_cand_idx;
  logic [NUM_REQ-1:0]            w_cand_req;
  logic [ID_W-1:0]               w_pick_idx;
  logic                          w_pick_hit;

  // Candidate gi is the requester gi places after the pointer, modulo NUM_REQ.
  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [ID_W:0] w_sum;
    assign w_sum = {1'b0, r_ptr} + (ID_W+1)'(gi);
    assign w_cand_idx[gi] = (w_sum >= (ID_W+1)'(NUM_REQ)) ?
                            ID_W'(w_sum - (ID_W+1)'(NUM_REQ)) : ID_W'(w_sum);
    assign w_cand_req[gi] = i_req[w_cand_idx[gi]];
  end

  always_comb begin
    w_pick_idx = '0;
    w_pick_hit = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_cand_req[k]) begin
        w_pick_idx = w_cand_idx[k];
        w_pick_hit = 1'b1;
      end
    end
  end

  assign o_gnt_valid = i_en & w_pick_hit;
  assign o_gnt_idx   = w_pick_idx;
  assign o_gnt       = o_gnt_valid ? (NUM_REQ'(1) << w_pick_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (o_gnt_valid) begin
      r_ptr <= (w_pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ahb3lite_rr_master.sv
// Round-robin AHB3-Lite master: single NONSEQ transfers through a two-slot
// address/data pipeline, with wait states and two-cycle ERROR reissue.
module ahb3lite_rr_master
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic HCLK,
  input  logic HRESET,
  ahb3lite_rr_master_if.master bus
);

  localparam int ID_W = id_width(NUM_REQ);

  slot_t                 r_a;
  dslot_t                r_d;
  err_state_t            r_err_state;
  err_state_t            w_err_state_next;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [ID_W-1:0]       r_rsp_id;
  logic [HDATA_SIZE-1:0] r_rsp_rdata;

  logic                  w_a_present;
  logic                  w_a_free;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [ID_W-1:0]       w_gnt_idx;
  logic                  w_gnt_valid;
  slot_t                 w_req_slot;
  logic                  w_d_done;

  // An error-held slot stays loaded but is hidden from the bus for one cycle.
  assign w_a_present = r_a.valid && (r_err_state == ERR_RUN);
  assign w_a_free    = !r_a.valid || (w_a_present && bus.HREADY);
  assign w_d_done    = r_d.valid && bus.HREADY;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk         (HCLK),
    .rst         (HRESET),
    .i_req       (bus.req_valid),
    .i_en        (w_a_free),
    .o_gnt       (w_gnt),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  always_comb begin
    w_req_slot       = '0;
    w_req_slot.valid = 1'b1;
    w_req_slot.addr  = SLOT_ADDR_W'(bus.req_addr[w_gnt_idx]);
    w_req_slot.write = bus.req_write[w_gnt_idx];
    w_req_slot.size  = bus.req_size[w_gnt_idx];
    w_req_slot.id    = SLOT_ID_W'(w_gnt_idx);
    w_req_slot.wdata = SLOT_DATA_W'(bus.req_wdata[w_gnt_idx]);
  end

  // Error FSM: first ERROR cycle (HREADY low) arms the hold, the completing cycle drops it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_err_state <= ERR_RUN;
    end else begin
      r_err_state <= w_err_state_next;
    end
  end

  always_comb begin
    w_err_state_next = r_err_state;
    case (r_err_state)
      ERR_RUN: begin
        if (r_d.valid && bus.HRESP && !bus.HREADY) begin
          w_err_state_next = ERR_HOLD;
        end
      end
      ERR_HOLD: begin
        if (bus.HREADY) begin
          w_err_state_next = ERR_RUN;
        end
      end
      default: w_err_state_next = ERR_RUN;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_a         <= '0;
      r_d         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_a_free) begin
        if (w_gnt_valid) begin
          r_a <= w_req_slot;
        end else begin
          r_a.valid <= 1'b0;
        end
      end

      if (bus.HREADY) begin
        if (w_a_present) begin
          r_d.valid <= 1'b1;
          r_d.write <= r_a.write;
          r_d.id    <= r_a.id;
          r_d.wdata <= r_a.wdata;
        end else begin
          r_d.valid <= 1'b0;
        end
      end

      r_rsp_valid <= w_d_done;
      if (w_d_done) begin
        r_rsp_id    <= ID_W'(r_d.id);
        r_rsp_err   <= bus.HRESP;
        r_rsp_rdata <= (r_d.write || bus.HRESP) ? '0 : bus.HRDATA;
      end else begin
        r_rsp_err   <= 1'b0;
      end
    end
  end

  assign bus.HSEL      = w_a_present;
  assign bus.HTRANS    = w_a_present ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = HADDR_SIZE'(r_a.addr);
  assign bus.HWRITE    = r_a.write;
  assign bus.HSIZE     = r_a.size;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_DATA_PRIV;
  assign bus.HWDATA    = r_d.valid ? HDATA_SIZE'(r_d.wdata) : '0;

  assign bus.req_ready = w_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ahb3lite_rr_master.sv
// Directed bench for ahb3lite_rr_master: a small AHB memory slave whose HREADY/HRESP
// are scripted cycle by cycle from the main sequence.
module tb_ahb3lite_rr_master;
  import ahb3lite_pkg::*;

  logic clk;
  logic rst;
  logic s_ready;
  logic s_resp;
  int   checks;
  int   failures;

  ahb3lite_rr_master_if #(.HADDR_SIZE(32), .HDATA_SIZE(32), .NUM_REQ(2)) bus ();

  ahb3lite_rr_master #(.HADDR_SIZE(32), .HDATA_SIZE(32), .NUM_REQ(2)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: latches the address phase, commits writes at the end of an OKAY data phase.
  logic [31:0] mem [0:31];
  logic        dp_valid;
  logic        dp_write;
  logic [31:0] dp_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 32'h0;
    end else if (bus.HREADY) begin
      if (dp_valid && dp_write && !bus.HRESP) mem[dp_addr[6:2]] <= bus.HWDATA;
      dp_valid <= bus.HSEL && (bus.HTRANS == HTRANS_NONSEQ);
      dp_addr  <= bus.HADDR;
      dp_write <= bus.HWRITE;
    end
  end

  assign bus.HREADY = s_ready;
  assign bus.HRESP  = s_resp;
  assign bus.HRDATA = (dp_valid && !dp_write) ? mem[dp_addr[6:2]] : 32'h0;

  always @(negedge clk) begin
    if (bus.rsp_valid)
      $display("rsp id=%0d err=%0b rdata=%08h t=%0t", bus.rsp_id, bus.rsp_err, bus.rsp_rdata, $time);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int r, input logic v, input logic [31:0] a,
                         input logic w, input logic [31:0] d);
    bus.req_valid[r] = v;
    bus.req_addr[r]  = a;
    bus.req_write[r] = w;
    bus.req_size[r]  = 3'b010;
    bus.req_wdata[r] = d;
  endtask

  function automatic logic [31:0] t2_addr(input int g);
    return ((g % 2) == 0 ? 32'h0 : 32'h40) + 32'(4 * (g / 2));
  endfunction

  int n0;
  int n1;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; s_ready = 1'b1; s_resp = 1'b0;
    set_req(0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); tick();

    // Reset values
    check("rst_hsel",   64'(bus.HSEL), 64'h0);
    check("rst_htrans", 64'(bus.HTRANS), 64'h0);
    check("rst_haddr",  64'(bus.HADDR), 64'h0);
    check("rst_hwdata", 64'(bus.HWDATA), 64'h0);
    check("rst_hwrite", 64'(bus.HWRITE), 64'h0);
    check("rst_hsize",  64'(bus.HSIZE), 64'h0);
    check("rst_ready",  64'(bus.req_ready), 64'h0);
    check("rst_rsp",    64'({bus.rsp_valid, bus.rsp_err, bus.rsp_id}), 64'h0);
    check("rst_rdata",  64'(bus.rsp_rdata), 64'h0);
    check("hburst",     64'(bus.HBURST), 64'h0);
    check("hprot",      64'(bus.HPROT), 64'h3);
    rst = 1'b0;
    tick();

    // Write then read 0x10, zero wait states
    set_req(0, 1'b1, 32'h10, 1'b1, 32'hDEADBEEF);
    #1 check("t1_ready_n", 64'(bus.req_ready), 64'h1);
    tick(); bus.req_valid = 2'b00;
    #1 check("t1_htrans_n1", 64'(bus.HTRANS), 64'h2);
    check("t1_haddr_n1", 64'(bus.HADDR), 64'h10);
    check("t1_hwrite_n1", 64'(bus.HWRITE), 64'h1);
    check("t1_rsp_n1", 64'(bus.rsp_valid), 64'h0);
    tick();
    #1 check("t1_htrans_n2", 64'(bus.HTRANS), 64'h0);
    check("t1_hwdata_n2", 64'(bus.HWDATA), 64'hDEADBEEF);
    check("t1_rsp_n2", 64'(bus.rsp_valid), 64'h0);
    tick();
    set_req(0, 1'b1, 32'h10, 1'b0, 32'h0);
    #1 check("t1_wrsp_n3", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_id}), 64'h4);
    check("t1_wrdata_n3", 64'(bus.rsp_rdata), 64'h0);
    check("t1_rd_ready", 64'(bus.req_ready), 64'h1);
    tick(); bus.req_valid = 2'b00;
    #1 check("t1_rd_htrans", 64'(bus.HTRANS), 64'h2);
    check("t1_rd_hwrite", 64'(bus.HWRITE), 64'h0);
    check("t1_rd_rsp_n4", 64'(bus.rsp_valid), 64'h0);
    tick();
    #1 check("t1_rd_rsp_n5", 64'(bus.rsp_valid), 64'h0);
    tick();
    #1 check("t1_rd_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_id}), 64'h4);
    check("t1_rd_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);

    // Two requesters, four writes each, zero wait states
    rst = 1'b1; tick(); rst = 1'b0; tick();
    n0 = 0; n1 = 0;
    for (int c = 0; c < 11; c++) begin
      set_req(0, n0 < 4, 32'(4 * n0), 1'b1, 32'hA5000000 | 32'(4 * n0));
      set_req(1, n1 < 4, 32'h40 + 32'(4 * n1), 1'b1, 32'hA5000040 | 32'(4 * n1));
      #1;
      if (c < 8) check($sformatf("t2_ready_c%0d", c), 64'(bus.req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
      if (c >= 1 && c <= 8) begin
        check($sformatf("t2_htrans_c%0d", c), 64'(bus.HTRANS), 64'h2);
        check($sformatf("t2_haddr_c%0d", c), 64'(bus.HADDR), 64'(t2_addr(c - 1)));
      end else begin
        check($sformatf("t2_idle_c%0d", c), 64'(bus.HTRANS), 64'h0);
      end
      if (c >= 2 && c <= 9)
        check($sformatf("t2_hwdata_c%0d", c), 64'(bus.HWDATA), 64'(32'hA5000000 | t2_addr(c - 2)));
      if (c >= 3)
        check($sformatf("t2_rsp_c%0d", c), 64'({bus.rsp_valid, bus.rsp_id}), 64'({1'b1, 1'((c - 3) % 2)}));
      else
        check($sformatf("t2_norsp_c%0d", c), 64'(bus.rsp_valid), 64'h0);
      if (bus.req_ready[0]) n0++;
      if (bus.req_ready[1]) n1++;
      tick();
    end
    bus.req_valid = 2'b00;
    #1 check("t2_rsp_end", 64'(bus.rsp_valid), 64'h0);

    // Two wait states on the first of a back-to-back pair
    tick();
    set_req(0, 1'b1, 32'h24, 1'b1, 32'h12345678);
    set_req(1, 1'b1, 32'h04, 1'b0, 32'h0);
    #1 check("t3_ready_m", 64'(bus.req_ready), 64'h1);
    tick(); bus.req_valid[0] = 1'b0;
    #1 check("t3_ready_m1", 64'(bus.req_ready), 64'h2);
    check("t3_haddr_m1", 64'(bus.HADDR), 64'h24);
    tick(); bus.req_valid[1] = 1'b0; s_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      if (w == 2) s_ready = 1'b1;
      #1;
      check($sformatf("t3_htrans_w%0d", w), 64'(bus.HTRANS), 64'h2);
      check($sformatf("t3_haddr_w%0d", w), 64'(bus.HADDR), 64'h04);
      check($sformatf("t3_hwdata_w%0d", w), 64'(bus.HWDATA), 64'h12345678);
      check($sformatf("t3_norsp_w%0d", w), 64'(bus.rsp_valid), 64'h0);
      tick();
    end
    #1 check("t3_rsp1", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_id}), 64'h4);
    check("t3_htrans_idle", 64'(bus.HTRANS), 64'h0);
    tick();
    #1 check("t3_rsp2", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_id}), 64'h5);
    check("t3_rdata2", 64'(bus.rsp_rdata), 64'hA5000004);
    tick();
    #1 check("t3_nodup", 64'(bus.rsp_valid), 64'h0);

    // ERROR on write 0x20 with read 0x24 in its address phase
    tick();
    set_req(0, 1'b1, 32'h20, 1'b1, 32'h00002020);
    set_req(1, 1'b1, 32'h24, 1'b0, 32'h0);
    #1 check("t4_ready_e", 64'(bus.req_ready), 64'h1);
    tick(); bus.req_valid[0] = 1'b0;
    #1 check("t4_ready_e1", 64'(bus.req_ready), 64'h2);
    tick(); bus.req_valid[1] = 1'b0; s_ready = 1'b0; s_resp = 1'b1;
    #1 check("t4_err1_htrans", 64'(bus.HTRANS), 64'h2);
    check("t4_err1_haddr", 64'(bus.HADDR), 64'h24);
    tick(); s_ready = 1'b1; s_resp = 1'b1;
    #1 check("t4_err2_htrans", 64'(bus.HTRANS), 64'h0);
    check("t4_err2_hsel", 64'(bus.HSEL), 64'h0);
    check("t4_err2_norsp", 64'(bus.rsp_valid), 64'h0);
    tick(); s_resp = 1'b0;
    #1 check("t4_err_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_id}), 64'h6);
    check("t4_reissue_htrans", 64'(bus.HTRANS), 64'h2);
    check("t4_reissue_haddr", 64'(bus.HADDR), 64'h24);
    check("t4_reissue_hwrite", 64'(bus.HWRITE), 64'h0);
    tick();
    #1 check("t4_norsp", 64'(bus.rsp_valid), 64'h0);
    tick();
    #1 check("t4_rd_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_id}), 64'h5);
    check("t4_rd_rdata", 64'(bus.rsp_rdata), 64'h12345678);

    // Reset with one transfer in data phase and one in address phase
    tick();
    set_req(0, 1'b1, 32'h30, 1'b1, 32'h33333333);
    set_req(1, 1'b1, 32'h04, 1'b0, 32'h0);
    #1 check("t5_ready_r", 64'(bus.req_ready), 64'h1);
    tick(); bus.req_valid[0] = 1'b0;
    #1 check("t5_ready_r1", 64'(bus.req_ready), 64'h2);
    tick(); bus.req_valid[1] = 1'b0;
    #1 check("t5_pre_htrans", 64'(bus.HTRANS), 64'h2);
    rst = 1'b1;
    #1 check("t5_async_htrans", 64'(bus.HTRANS), 64'h0);
    check("t5_async_hsel", 64'(bus.HSEL), 64'h0);
    check("t5_async_hwdata", 64'(bus.HWDATA), 64'h0);
    tick(); rst = 1'b0;
    for (int q = 0; q < 3; q++) begin
      #1 check($sformatf("t5_norsp_%0d", q), 64'(bus.rsp_valid), 64'h0);
      tick();
    end
    set_req(0, 1'b1, 32'h30, 1'b0, 32'h0);
    set_req(1, 1'b1, 32'h04, 1'b0, 32'h0);
    #1 check("t5_after_ready", 64'(bus.req_ready), 64'h1);
    tick(); bus.req_valid = 2'b00;
    tick(); tick();
    #1 check("t5_after_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_id}), 64'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
